// File: rtl/jam_cost_table.sv
// ---------------------------------------------------------------------------
// jam_cost_table
// Responder side of the job-assignment worker/job/cost query interface.
// Holds an N x N worker-by-job cost matrix that a host loads serially
// (row-major: worker-major, job-minor). The assignment engine then queries
// (W, J) and receives Cost in the same cycle. The engine's final
// (MinCost, MatchCount) result is captured on its Valid strobe.
//
// Ports:
//   CLK, RST      clock (rising edge), asynchronous active-low reset
//   ld_valid      loader offers ld_data
//   ld_ready      table accepts a load word (high only while loading)
//   ld_data       cost entry to store
//   clear         synchronous restart to the load phase
//   W, J          queried worker / job
//   Cost          cost of (W, J), combinational, zero while loading
//   Valid         engine result strobe
//   MinCost       engine minimum total
//   MatchCount    engine match count
//   table_ready   table fully loaded, queries valid (registered)
//   res_valid     result captured (registered)
//   res_min       captured MinCost (registered)
//   res_match     captured MatchCount (registered)
//   serve_cycles  cycles spent serving, saturating at 16'hFFFF (registered)
// ---------------------------------------------------------------------------
module jam_cost_table #(
  parameter int N      = 8,
  parameter int IDX_W  = 3,
  parameter int COST_W = 7
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [COST_W-1:0] ld_data,
  input  logic              clear,
  input  logic [IDX_W-1:0]  W,
  input  logic [IDX_W-1:0]  J,
  output logic [COST_W-1:0] Cost,
  input  logic              Valid,
  input  logic [9:0]        MinCost,
  input  logic [3:0]        MatchCount,
  output logic              table_ready,
  output logic              res_valid,
  output logic [9:0]        res_min,
  output logic [3:0]        res_match,
  output logic [15:0]       serve_cycles
);

  localparam int DEPTH = N * N;
  localparam int PTR_W = 2 * IDX_W;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_r;
  logic [PTR_W-1:0]  ptr_r;
  logic [COST_W-1:0] table_r [DEPTH];
  logic [PTR_W-1:0]  addr_s;
  logic              ptr_last_s;

  assign addr_s     = {W, J};
  assign ptr_last_s = (ptr_r == {PTR_W{1'b1}});

  // Load handshake and query port: both decoded directly from state so the
  // engine sees Cost in the same cycle it drives W/J.
  always_comb begin
    ld_ready = 1'b0;
    Cost     = {COST_W{1'b0}};
    if (state_r == ST_LOAD) begin
      ld_ready = 1'b1;
      Cost     = {COST_W{1'b0}};
    end else begin
      ld_ready = 1'b0;
      Cost     = table_r[addr_s];
    end
  end

  // Phase control, table storage, result capture and serve-cycle counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r      <= ST_LOAD;
      ptr_r        <= {PTR_W{1'b0}};
      table_ready  <= 1'b0;
      res_valid    <= 1'b0;
      res_min      <= 10'd0;
      res_match    <= 4'd0;
      serve_cycles <= 16'd0;
      for (int i = 0; i < DEPTH; i++) begin
        table_r[i] <= {COST_W{1'b0}};
      end
    end else if (clear) begin
      // Restart loading; old table contents and the last result values
      // stay visible until overwritten.
      state_r      <= ST_LOAD;
      ptr_r        <= {PTR_W{1'b0}};
      table_ready  <= 1'b0;
      res_valid    <= 1'b0;
      serve_cycles <= 16'd0;
    end else begin
      case (state_r)
        ST_LOAD: begin
          // Valid is deliberately ignored here, even on the final accept.
          if (ld_valid) begin
            table_r[ptr_r] <= ld_data;
            ptr_r          <= ptr_r + PTR_W'(1);
            if (ptr_last_s) begin
              state_r     <= ST_SERVE;
              table_ready <= 1'b1;
            end else begin
              state_r     <= ST_LOAD;
            end
          end else begin
            state_r <= ST_LOAD;
          end
        end
        ST_SERVE: begin
          if (serve_cycles != 16'hFFFF) begin
            serve_cycles <= serve_cycles + 16'd1;
          end else begin
            serve_cycles <= serve_cycles;
          end
          if (Valid) begin
            res_min   <= MinCost;
            res_match <= MatchCount;
            res_valid <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            state_r   <= ST_SERVE;
          end
        end
        ST_DONE: begin
          state_r <= ST_DONE;
        end
        default: begin
          state_r     <= ST_LOAD;
          ptr_r       <= {PTR_W{1'b0}};
          table_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jam_cost_table.sv
// ---------------------------------------------------------------------------
// tb_jam_cost_table
// Self-checking bench for jam_cost_table: directed scenarios plus a random
// phase, all compared against a behavioural model held in this module.
// ---------------------------------------------------------------------------
module tb_jam_cost_table;

  logic       CLK;
  logic       RST;
  logic       ld_valid;
  logic       ld_ready;
  logic [6:0] ld_data;
  logic       clear;
  logic [2:0] W;
  logic [2:0] J;
  logic [6:0] Cost;
  logic       Valid;
  logic [9:0] MinCost;
  logic [3:0] MatchCount;
  logic       table_ready;
  logic       res_valid;
  logic [9:0] res_min;
  logic [3:0] res_match;
  logic [15:0] serve_cycles;

  int n_tests;
  int n_fail;

  // behavioural model
  int m_tab [64];
  int m_count;      // words accepted in the current load
  bit m_loaded;     // full table loaded since last clear/reset
  bit m_have_res;   // result captured since last clear/reset
  int m_min;
  int m_match;
  int m_serve;

  jam_cost_table dut (
    .CLK          (CLK),
    .RST          (RST),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_data      (ld_data),
    .clear        (clear),
    .W            (W),
    .J            (J),
    .Cost         (Cost),
    .Valid        (Valid),
    .MinCost      (MinCost),
    .MatchCount   (MatchCount),
    .table_ready  (table_ready),
    .res_valid    (res_valid),
    .res_min      (res_min),
    .res_match    (res_match),
    .serve_cycles (serve_cycles)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_value(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) m_tab[i] = 0;
    m_count = 0; m_loaded = 0; m_have_res = 0;
    m_min = 0; m_match = 0; m_serve = 0;
  endfunction

  // One clock edge of the model, using the inputs currently driven.
  function automatic void model_step();
    if (clear) begin
      m_count = 0; m_loaded = 0; m_have_res = 0; m_serve = 0;
    end else if (!m_loaded) begin
      if (ld_valid) begin
        m_tab[m_count] = int'(ld_data);
        m_count++;
        if (m_count == 64) begin
          m_count  = 0;
          m_loaded = 1;
        end
      end
    end else if (!m_have_res) begin
      if (m_serve < 65535) m_serve++;
      if (Valid) begin
        m_have_res = 1;
        m_min      = int'(MinCost);
        m_match    = int'(MatchCount);
      end
    end
  endfunction

  task automatic compare_all();
    int exp_cost;
    exp_cost = m_loaded ? m_tab[int'(W) * 8 + int'(J)] : 0;
    check_value("ld_ready",     int'(ld_ready),     m_loaded ? 0 : 1);
    check_value("cost",         int'(Cost),         exp_cost);
    check_value("table_ready",  int'(table_ready),  int'(m_loaded));
    check_value("res_valid",    int'(res_valid),    int'(m_have_res));
    check_value("res_min",      int'(res_min),      m_min);
    check_value("res_match",    int'(res_match),    m_match);
    check_value("serve_cycles", int'(serve_cycles), m_serve);
  endtask

  // Called at a negedge with inputs already driven; returns at next negedge.
  task automatic tick();
    #1;
    compare_all();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    ld_valid = 1'b0; ld_data = 7'd0; clear = 1'b0;
    Valid = 1'b0; MinCost = 10'd0; MatchCount = 4'd0;
  endtask

  // Query (w, j) against a literal expected value, then advance one cycle.
  task automatic probe(input int w, input int j, input int exp, input string tag);
    idle_inputs();
    W = 3'(w); J = 3'(j);
    #1;
    check_value(tag, int'(Cost), exp);
    tick();
  endtask

  task automatic do_clear();
    idle_inputs();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic async_reset();
    RST = 1'b0;
    #1;
    model_reset();
    compare_all();
    RST = 1'b1;
    #1;
    @(negedge CLK);
  endtask

  initial begin
    int sum;
    int sc0;
    n_tests = 0; n_fail = 0;
    RST = 1'b0;
    W = 3'd0; J = 3'd0;
    idle_inputs();
    model_reset();
    @(negedge CLK);
    #1;
    compare_all();
    check_value("rst_ld_ready", int'(ld_ready), 1);
    RST = 1'b1;
    @(negedge CLK);

    // Load (w,j) = 8w+j with ld_valid held high.
    for (int i = 0; i < 64; i++) begin
      ld_valid = 1'b1; ld_data = 7'(i);
      W = 3'($urandom_range(0, 7)); J = 3'($urandom_range(0, 7));
      tick();
    end
    ld_valid = 1'b0;
    check_value("tr_after_64", int'(table_ready), 1);
    check_value("ldr_after_64", int'(ld_ready), 0);
    probe(3, 5, 29, "cost_3_5");
    probe(7, 7, 63, "cost_7_7");

    // Reload with toggling ld_valid, data = 64 - index.
    do_clear();
    for (int i = 0; i < 128; i++) begin
      ld_valid = (i % 2 == 0);
      ld_data  = 7'(64 - i / 2);
      tick();
    end
    probe(0, 0, 64, "cost_0_0_tog");
    probe(7, 7, 1, "cost_7_7_tog");
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = 7'd100;
      W = 3'(i); J = 3'd0;
      tick();
    end
    ld_valid = 1'b0;
    probe(0, 0, 64, "cost_after_extra");
    probe(0, 1, 63, "cost_0_1_after_extra");

    // Result capture and hold.
    idle_inputs();
    Valid = 1'b1; MinCost = 10'd123; MatchCount = 4'd2;
    tick();
    idle_inputs();
    check_value("res_valid_cap", int'(res_valid), 1);
    check_value("res_min_cap", int'(res_min), 123);
    check_value("res_match_cap", int'(res_match), 2);
    sc0 = m_serve;
    tick(); tick();
    Valid = 1'b1; MinCost = 10'd5; MatchCount = 4'd7;
    tick();
    idle_inputs();
    tick();
    check_value("res_min_hold", int'(res_min), 123);
    check_value("serve_frozen", int'(serve_cycles), sc0);

    // Clear in DONE, reload with 9s; Valid on the final accept is ignored.
    do_clear();
    #1;
    check_value("clr_tr", int'(table_ready), 0);
    check_value("clr_rv", int'(res_valid), 0);
    check_value("clr_ldr", int'(ld_ready), 1);
    check_value("clr_cost", int'(Cost), 0);
    check_value("clr_res_min", int'(res_min), 123);
    @(negedge CLK);
    for (int i = 0; i < 64; i++) begin
      ld_valid = 1'b1; ld_data = 7'd9;
      Valid = (i == 63); MinCost = 10'd55; MatchCount = 4'd3;
      tick();
    end
    idle_inputs();
    check_value("rv_after_final_valid", int'(res_valid), 0);
    for (int i = 0; i < 64; i++) probe(i / 8, i % 8, 9, "cost_nine");

    // Reset mid-load, then load 1s with a Valid pulse during load.
    do_clear();
    for (int i = 0; i < 20; i++) begin
      ld_valid = 1'b1; ld_data = 7'd42;
      tick();
    end
    idle_inputs();
    async_reset();
    check_value("rst_mid_tr", int'(table_ready), 0);
    check_value("rst_mid_ldr", int'(ld_ready), 1);
    for (int i = 0; i < 64; i++) begin
      ld_valid = 1'b1; ld_data = 7'd1;
      Valid = (i == 10); MinCost = 10'd77; MatchCount = 4'd1;
      tick();
    end
    idle_inputs();
    check_value("load_valid_rv", int'(res_valid), 0);
    check_value("load_valid_min", int'(res_min), 0);
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      W = 3'(i); J = 3'((i + 3) % 8);
      #1;
      sum += int'(Cost);
      tick();
    end
    check_value("diag_sum", sum, 8);

    // Random phase.
    for (int i = 0; i < 1500; i++) begin
      ld_valid   = ($urandom_range(0, 1) == 1);
      ld_data    = 7'($urandom_range(0, 127));
      clear      = ($urandom_range(0, 199) == 0);
      Valid      = ($urandom_range(0, 39) == 0);
      MinCost    = 10'($urandom_range(0, 1023));
      MatchCount = 4'($urandom_range(0, 15));
      W          = 3'($urandom_range(0, 7));
      J          = 3'($urandom_range(0, 7));
      tick();
    end
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
